// File: rtl/rv32i_pkg.sv
// rv32i_pkg: shared memory-access encodings, LSU states and lane helpers
package rv32i_pkg;

    typedef enum logic [2:0] {
        MEM_B  = 3'd0,
        MEM_H  = 3'd1,
        MEM_W  = 3'd2,
        MEM_BU = 3'd4,
        MEM_HU = 3'd5
    } mem_unit_e;

    typedef enum logic [1:0] {
        IDLE,
        BUS,
        DONE
    } lsu_state_e;

    // Codes 3, 6 and 7 are not byte or halfword, so they fall through to word.
    function automatic logic lsu_is_byte(input logic [2:0] unit);
        return unit == MEM_B || unit == MEM_BU;
    endfunction

    function automatic logic lsu_is_half(input logic [2:0] unit);
        return unit == MEM_H || unit == MEM_HU;
    endfunction

    function automatic logic [3:0] lsu_be(input logic [2:0] unit, input logic [1:0] off);
        return lsu_is_byte(unit) ? 4'b0001 << off : lsu_is_half(unit) ? 4'b0011 << off : 4'b1111;
    endfunction

    function automatic logic [31:0] lsu_wdata(input logic [2:0] unit, input logic [31:0] w);
        return lsu_is_byte(unit) ? {4{w[7:0]}} : lsu_is_half(unit) ? {2{w[15:0]}} : w;
    endfunction

    function automatic logic lsu_misaligned(input logic [2:0] unit, input logic [1:0] off);
        return lsu_is_byte(unit) ? 1'b0 : lsu_is_half(unit) ? off[0] : |off;
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// lsu_load_align: picks the addressed byte/halfword lane and sign- or zero-extends it
module lsu_load_align
    import rv32i_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  off,
    input  logic [2:0]  unit,
    output logic [31:0] data
);

    logic [7:0]  b;
    logic [15:0] h;
    logic        sx;

    // Unsigned variants carry bit 2 of the size code, so sign extension is its inverse.
    always_comb begin
        b    = rdata[{off, 3'b000} +: 8];
        h    = rdata[{off[1], 4'b0000} +: 16];
        sx   = ~unit[2];
        data = lsu_is_byte(unit) ? {{24{sx & b[7]}}, b} :
               lsu_is_half(unit) ? {{16{sx & h[15]}}, h} : rdata;
    end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: multi-cycle load/store over a req/ready word bus; optional trap via LSU_MISALIGN_TRAP_EN
module load_store_unit
    import rv32i_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [2:0]        mem_unit,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              stall,
    output logic              misalign,
    output logic              bus_req,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [3:0]        bus_be,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic              bus_ready,
    input  logic [DATA_W-1:0] bus_rdata
);

    if (DATA_W != 32) begin : g_bad_width
        $error("load_store_unit supports DATA_W = 32 only");
    end

    lsu_state_e        state_q, state_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [1:0]        off_q, off_d;
    logic [3:0]        be_q, be_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [2:0]        unit_q, unit_d;
    logic [DATA_W-1:0] load_data;
`ifdef LSU_MISALIGN_TRAP_EN
    logic              misalign_q, misalign_d;
`endif

    lsu_load_align u_align (
        .rdata (bus_rdata),
        .off   (off_q),
        .unit  (unit_q),
        .data  (load_data)
    );

    // Next-state and stall: latch the access in IDLE, hold it on the bus until ready, release in DONE.
    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        addr_d  = addr_q;
        off_d   = off_q;
        be_d    = be_q;
        wdata_d = wdata_q;
        unit_d  = unit_q;
        rdata_d = rdata_q;
        stall   = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
        misalign_d = 1'b0;
`endif
        case (state_q)
            IDLE: if (mem_read || mem_write) begin
                stall = 1'b1;
`ifdef LSU_MISALIGN_TRAP_EN
                if (lsu_misaligned(mem_unit, addr[1:0])) begin
                    state_d    = DONE;
                    misalign_d = 1'b1;
                end else begin
`else
                begin
`endif
                    state_d = BUS;
                    we_d    = mem_write;
                    addr_d  = {addr[ADDR_W-1:2], 2'b00};
                    off_d   = addr[1:0];
                    be_d    = lsu_be(mem_unit, addr[1:0]);
                    wdata_d = lsu_wdata(mem_unit, wdata);
                    unit_d  = mem_unit;
                end
            end
            BUS: begin
                stall = 1'b1;
                if (bus_ready) begin
                    state_d = DONE;
                    rdata_d = we_q ? rdata_q : load_data;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State and latched access registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            addr_q  <= '0;
            off_q   <= 2'b00;
            be_q    <= 4'b0000;
            wdata_q <= '0;
            unit_q  <= 3'd0;
            rdata_q <= '0;
`ifdef LSU_MISALIGN_TRAP_EN
            misalign_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            off_q   <= off_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            unit_q  <= unit_d;
            rdata_q <= rdata_d;
`ifdef LSU_MISALIGN_TRAP_EN
            misalign_q <= misalign_d;
`endif
        end
    end

    assign rdata     = rdata_q;
    assign bus_req   = state_q == BUS;
    assign bus_we    = we_q;
    assign bus_addr  = addr_q;
    assign bus_be    = be_q;
    assign bus_wdata = wdata_q;
`ifdef LSU_MISALIGN_TRAP_EN
    assign misalign  = misalign_q;
`else
    assign misalign  = 1'b0;
`endif

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: randomized and directed loads/stores checked each cycle against a behavioural model
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_read, mem_write;
    logic [2:0]  mem_unit;
    logic [31:0] addr, wdata, rdata, bus_addr, bus_wdata, bus_rdata;
    logic        stall, misalign, bus_req, bus_we, bus_ready;
    logic [3:0]  bus_be;

    load_store_unit dut (
        .clk       (clk),
        .rst       (rst),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .mem_unit  (mem_unit),
        .addr      (addr),
        .wdata     (wdata),
        .rdata     (rdata),
        .stall     (stall),
        .misalign  (misalign),
        .bus_req   (bus_req),
        .bus_we    (bus_we),
        .bus_addr  (bus_addr),
        .bus_be    (bus_be),
        .bus_wdata (bus_wdata),
        .bus_ready (bus_ready),
        .bus_rdata (bus_rdata)
    );

    always #5 clk = ~clk;

`ifdef LSU_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    int checks = 0;
    int errors = 0;

    bit          chk_en = 1'b0;
    logic        exp_stall, exp_req, exp_mis, exp_we;
    logic [31:0] exp_addr, exp_wd, model_rdata;
    logic [3:0]  exp_be;

    int          run = 0, last_run = 0, mis_cnt = 0, req_cnt = 0;
    logic [3:0]  last_be;
    logic [31:0] last_addr, last_wd;
    logic        last_we;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic int m_size(input logic [2:0] u);
        return (u == 0 || u == 4) ? 1 : (u == 1 || u == 5) ? 2 : 4;
    endfunction

    function automatic logic [3:0] m_be(input logic [2:0] u, input int off);
        logic [3:0] r;
        int sz = m_size(u);
        for (int i = 0; i < 4; i++) r[i] = (sz == 4) || (i >= off && i < off + sz);
        return r;
    endfunction

    function automatic logic [31:0] m_wd(input logic [2:0] u, input logic [31:0] w);
        logic [31:0] r;
        int sz = m_size(u);
        for (int i = 0; i < 4; i++) r[8*i +: 8] = w[8*(i % sz) +: 8];
        return r;
    endfunction

    function automatic logic [31:0] m_ld(input logic [2:0] u, input int off, input logic [31:0] word);
        int sz = m_size(u);
        int sel = (sz == 1) ? off : (sz == 2) ? (off & 2) : 0;
        logic [31:0] mask = (sz == 4) ? 32'hFFFF_FFFF : (32'h1 << (8 * sz)) - 32'h1;
        logic [31:0] v = (word >> (8 * sel)) & mask;
        if (sz < 4 && u < 4 && v[8*sz-1]) v = v | ~mask;
        return v;
    endfunction

    function automatic bit m_trap(input logic [2:0] u, input int off);
        int sz = m_size(u);
        return TRAP && ((sz == 2 && off % 2 == 1) || (sz == 4 && off != 0));
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            chk("stall", stall, exp_stall);
            chk("bus_req", bus_req, exp_req);
            chk("misalign", misalign, exp_mis);
            chk("rdata", rdata, model_rdata);
            if (exp_req) begin
                chk("bus_we", bus_we, exp_we);
                chk("bus_addr", bus_addr, exp_addr);
                chk("bus_be", bus_be, exp_be);
                chk("bus_wdata", bus_wdata, exp_wd);
            end
            if (stall) run <= run + 1;
            else if (run > 0) begin
                last_run <= run;
                run <= 0;
            end
            if (bus_req) begin
                last_be   <= bus_be;
                last_addr <= bus_addr;
                last_wd   <= bus_wdata;
                last_we   <= bus_we;
            end
            mis_cnt <= mis_cnt + int'(misalign);
            req_cnt <= req_cnt + int'(bus_req);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            cyc();
            mem_read  = 1'b0;
            mem_write = 1'b0;
            bus_ready = 1'($urandom_range(0, 1));
            bus_rdata = $urandom;
            exp_stall = 1'b0;
            exp_req   = 1'b0;
            exp_mis   = 1'b0;
        end
    endtask

    task automatic op(input bit rd, input bit wr, input logic [2:0] u, input logic [31:0] a,
                      input logic [31:0] w, input int wt, input logic [31:0] word);
        int off = int'(a[1:0]);
        bit acc = rd | wr;
        cyc();
        mem_read  = rd;
        mem_write = wr;
        mem_unit  = u;
        addr      = a;
        wdata     = w;
        bus_ready = 1'($urandom_range(0, 1));
        bus_rdata = $urandom;
        exp_stall = acc;
        exp_req   = 1'b0;
        exp_mis   = 1'b0;
        if (!acc) return;
        if (m_trap(u, off)) begin
            cyc();
            bus_ready = 1'($urandom_range(0, 1));
            exp_stall = 1'b0;
            exp_mis   = 1'b1;
            return;
        end
        exp_we   = wr;
        exp_addr = {a[31:2], 2'b00};
        exp_be   = m_be(u, off);
        exp_wd   = m_wd(u, w);
        for (int j = 0; j <= wt; j++) begin
            cyc();
            exp_req   = 1'b1;
            exp_stall = 1'b1;
            bus_ready = (j == wt);
            bus_rdata = (j == wt) ? word : $urandom;
        end
        cyc();
        exp_req   = 1'b0;
        exp_stall = 1'b0;
        bus_ready = 1'($urandom_range(0, 1));
        bus_rdata = $urandom;
        if (!wr) model_rdata = m_ld(u, off, word);
    endtask

    initial begin
        int m0, q0;
        rst = 1'b1;
        mem_read = 1'b0; mem_write = 1'b0; mem_unit = 3'd0;
        addr = '0; wdata = '0; bus_ready = 1'b0; bus_rdata = '0;
        exp_stall = 1'b0; exp_req = 1'b0; exp_mis = 1'b0; exp_we = 1'b0;
        exp_addr = '0; exp_wd = '0; exp_be = '0; model_rdata = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk_en = 1'b1;
        chk("rst_bus_we", bus_we, 0);
        chk("rst_bus_addr", bus_addr, 0);
        chk("rst_bus_be", bus_be, 0);
        chk("rst_bus_wdata", bus_wdata, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_stall", stall, 0);

        chk("model_be_sb", m_be(3'd0, 3), 32'h8);
        chk("model_wd_sb", m_wd(3'd0, 32'hAB), 32'hABABABAB);
        chk("model_lb", m_ld(3'd0, 2, 32'h80FF1234), 32'hFFFFFFFF);
        chk("model_lbu", m_ld(3'd4, 2, 32'h80FF1234), 32'h000000FF);
        chk("model_lh", m_ld(3'd1, 2, 32'h80FF1234), 32'hFFFF80FF);

        op(1'b0, 1'b1, 3'd0, 32'h103, 32'hAB, 0, 32'h0);
        idle(1);
        chk("sb_be", last_be, 32'h8);
        chk("sb_wdata", last_wd, 32'hABABABAB);
        chk("sb_addr", last_addr, 32'h100);
        chk("sb_stall_cycles", last_run, 2);

        op(1'b1, 1'b0, 3'd0, 32'h2, 32'h0, 0, 32'h80FF1234);
        idle(1);
        chk("lb_rdata", rdata, 32'hFFFFFFFF);
        op(1'b1, 1'b0, 3'd4, 32'h2, 32'h0, 1, 32'h80FF1234);
        idle(1);
        chk("lbu_rdata", rdata, 32'h000000FF);
        op(1'b1, 1'b0, 3'd1, 32'h2, 32'h0, 0, 32'h80FF1234);
        idle(1);
        chk("lh_rdata", rdata, 32'hFFFF80FF);

        op(1'b1, 1'b0, 3'd2, 32'h40, 32'h0, 3, 32'hCAFEF00D);
        idle(1);
        chk("lw_stall_cycles", last_run, 5);
        chk("lw_rdata", rdata, 32'hCAFEF00D);

        op(1'b1, 1'b1, 3'd2, 32'h10, 32'h12345678, 0, 32'h0BADBEEF);
        idle(1);
        chk("both_we", last_we, 1);
        chk("both_rdata", rdata, 32'hCAFEF00D);

        m0 = mis_cnt;
        q0 = req_cnt;
        op(1'b1, 1'b0, 3'd2, 32'h6, 32'h0, 0, 32'h11223344);
        idle(1);
`ifdef LSU_MISALIGN_TRAP_EN
        chk("trap_misalign_cycles", mis_cnt - m0, 1);
        chk("trap_bus_cycles", req_cnt - q0, 0);
        chk("trap_stall_cycles", last_run, 1);
        chk("trap_rdata", rdata, 32'hCAFEF00D);
`else
        chk("mis_bus_cycles", req_cnt - q0, 1);
        chk("mis_addr", last_addr, 32'h4);
        chk("mis_be", last_be, 32'hF);
        chk("mis_rdata", rdata, 32'h11223344);
`endif

        cyc();
        mem_read = 1'b1; mem_write = 1'b0; mem_unit = 3'd2; addr = 32'h20;
        bus_ready = 1'b0; exp_stall = 1'b1; exp_req = 1'b0; exp_mis = 1'b0;
        cyc();
        exp_req = 1'b1; exp_we = 1'b0; exp_addr = 32'h20; exp_be = 4'hF; exp_wd = m_wd(3'd2, wdata);
        bus_ready = 1'b0;
        rst = 1'b1;
        cyc();
        rst = 1'b0; mem_read = 1'b0;
        exp_req = 1'b0; exp_stall = 1'b0; model_rdata = '0;
        bus_ready = 1'b1; bus_rdata = 32'hDEADBEEF;
        idle(2);
        chk("rst_bus_req", bus_req, 0);
        chk("rst_mid_rdata", rdata, 0);
        chk("rst_mid_be", bus_be, 0);

        repeat (200) begin
            int k = $urandom_range(0, 3);
            op(k[0], k[1], 3'($urandom_range(0, 7)), $urandom, $urandom,
               $urandom_range(0, 3), $urandom);
            if ($urandom_range(0, 1) == 1) idle(1);
        end
        idle(2);
        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
